// File: rtl/audio_pkg.sv
// Shared constants and state type for the I2S audio transmit path.
// Frame geometry is fixed at 64 bit-clock slots per stereo frame.
package audio_pkg;
   localparam int FRAME_SLOTS    = 64;
   localparam int LEFT_MSB_SLOT  = 1;
   localparam int RIGHT_MSB_SLOT = 33;

   typedef enum logic {
      IDLE,
      RUN
   } tx_state_t;
endpackage

// File: rtl/audio_fifo.sv
// Small power-of-two sample FIFO with occupancy count.
// Pushes while full and pops while empty are ignored.
module audio_fifo #(
   parameter int WIDTH = 20,
   parameter int DEPTH = 4
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   push,
   input  logic [WIDTH-1:0]       wdata,
   input  logic                   pop,
   output logic [WIDTH-1:0]       rdata,
   output logic [$clog2(DEPTH):0] level
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && (level != (AW+1)'(DEPTH));
   assign do_pop  = pop && (level != '0);
   assign rdata   = mem[rptr];

   always_ff @(posedge clock) begin
      if (do_push) mem[wptr] <= wdata;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wptr  <= '0;
         rptr  <= '0;
         level <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop) rptr <= rptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end
endmodule

// File: rtl/dac_i2s_tx.sv
// Mono-to-stereo I2S transmitter fed by a CPU output port through a FIFO.
// All serial outputs are registered; data and word select move as bclk falls.
module dac_i2s_tx #(
   parameter int DWIDTH    = 32,
   parameter int SAMPLEW   = 20,
   parameter int BCLKDIV   = 2,
   parameter int FIFODEPTH = 4
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         wvalid,
   input  logic [DWIDTH-1:0]            wdata,
   output logic                         wready,
   input  logic                         enable,
   input  logic                         underrun_clr,
   output logic                         bclk,
   output logic                         lrclk,
   output logic                         sdata,
   output logic                         underrun,
   output logic [$clog2(FIFODEPTH):0]   level
);
   import audio_pkg::*;

   localparam int LW    = $clog2(FIFODEPTH) + 1;
   localparam int DIVW  = $clog2(2 * BCLKDIV);
   localparam int SLOTW = $clog2(FRAME_SLOTS);
   localparam logic [DIVW-1:0] DIV_LAST = DIVW'(2 * BCLKDIV - 1);
   localparam logic [DIVW-1:0] DIV_HIGH = DIVW'(BCLKDIV);

   tx_state_t          state;
   logic [DIVW-1:0]    div;
   logic [SLOTW-1:0]   slot;
   logic [SAMPLEW-1:0] sample;
   logic [SAMPLEW-1:0] rdata;
   logic               push;
   logic               pop;
   logic               empty;
   logic               slot_end;
   logic               frame_end;
   logic [DIVW-1:0]    div_n;
   logic [SLOTW-1:0]   slot_n;
   logic [SAMPLEW-1:0] sample_n;
   logic [6:0]         pos;
   logic [SAMPLEW-1:0] shifted;
   logic               bit_n;
   logic               unused_hi;

   assign unused_hi = ^wdata[DWIDTH-1:SAMPLEW];

   assign wready    = level != LW'(FIFODEPTH);
   assign push      = wvalid && wready;
   assign empty     = level == '0;
   assign slot_end  = div == DIV_LAST;
   assign frame_end = (state == RUN) && slot_end &&
                      (slot == SLOTW'(FRAME_SLOTS - 1));
   assign pop       = enable && !empty &&
                      ((state == IDLE) || frame_end);

   audio_fifo #(
      .WIDTH (SAMPLEW),
      .DEPTH (FIFODEPTH)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (push),
      .wdata (wdata[SAMPLEW-1:0]),
      .pop   (pop),
      .rdata (rdata),
      .level (level)
   );

   // Position of the next slot relative to its channel MSB slot.
   always_comb begin
      div_n    = slot_end ? '0 : div + 1'b1;
      slot_n   = slot_end ? slot + 1'b1 : slot;
      sample_n = sample;
      if (frame_end) sample_n = empty ? '0 : rdata;
      pos      = 7'(slot_n) - 7'(slot_n[SLOTW-1] ? RIGHT_MSB_SLOT
                                                 : LEFT_MSB_SLOT);
      shifted  = sample_n << pos;
      bit_n    = !pos[6] && (pos < 7'(SAMPLEW)) &&
                 shifted[SAMPLEW-1];
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         div      <= '0;
         slot     <= '0;
         sample   <= '0;
         bclk     <= 1'b0;
         lrclk    <= 1'b0;
         sdata    <= 1'b0;
         underrun <= 1'b0;
      end else begin
         if (frame_end && enable && empty) underrun <= 1'b1;
         else if (underrun_clr) underrun <= 1'b0;

         unique case (state)
            IDLE: begin
               if (enable && !empty) begin
                  state  <= RUN;
                  div    <= '0;
                  slot   <= '0;
                  sample <= rdata;
               end
            end
            RUN: begin
               if (frame_end && !enable) begin
                  state <= IDLE;
                  div   <= '0;
                  slot  <= '0;
                  bclk  <= 1'b0;
                  lrclk <= 1'b0;
                  sdata <= 1'b0;
               end else begin
                  div    <= div_n;
                  slot   <= slot_n;
                  sample <= sample_n;
                  bclk   <= div_n >= DIV_HIGH;
                  if (div_n == '0) begin
                     lrclk <= slot_n[SLOTW-1];
                     sdata <= bit_n;
                  end
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_dac_i2s_tx.sv
// Scenario bench for dac_i2s_tx with a sample scoreboard queue.
// Outputs are sampled on the falling clock edge.
module tb_dac_i2s_tx;
   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        wvalid = 1'b0;
   logic [31:0] wdata = '0;
   logic        wready;
   logic        enable = 1'b0;
   logic        underrun_clr = 1'b0;
   logic        bclk;
   logic        lrclk;
   logic        sdata;
   logic        underrun;
   logic [2:0]  level;

   int          vectors = 0;
   int          miscompares = 0;
   logic [19:0] q[$];
   logic        exp_ur = 1'b0;

   dac_i2s_tx dut (
      .clock        (clock),
      .reset        (reset),
      .wvalid       (wvalid),
      .wdata        (wdata),
      .wready       (wready),
      .enable       (enable),
      .underrun_clr (underrun_clr),
      .bclk         (bclk),
      .lrclk        (lrclk),
      .sdata        (sdata),
      .underrun     (underrun),
      .level        (level)
   );

   always #5 clock = ~clock;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic exp_bit(input logic [19:0] s, input int sl);
      if (sl >= 1 && sl <= 20) return s[20 - sl];
      if (sl >= 33 && sl <= 52) return s[52 - sl];
      return 1'b0;
   endfunction

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1;
      enable = 1'b0;
      wvalid = 1'b0;
      underrun_clr = 1'b0;
      @(negedge clock);
      reset = 1'b0;
      q.delete();
      exp_ur = 1'b0;
   endtask

   task automatic push_word(input logic [31:0] d);
      @(negedge clock);
      wvalid = 1'b1;
      wdata = d;
      if (q.size() < 4) q.push_back(d[19:0]);
      @(posedge clock);
      #1 wvalid = 1'b0;
   endtask

   task automatic wait_start(output logic [19:0] s);
      int n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (bclk !== 1'b1 && n < 40);
      vectors++;
      if (bclk !== 1'b1) begin
         miscompares++;
         $display("FAIL start: bclk got %b want 1 within 40 clocks", bclk);
      end
      s = (q.size() != 0) ? q.pop_front() : '0;
   endtask

   task automatic next_sample(output logic [19:0] s);
      if (q.size() != 0) s = q.pop_front();
      else begin
         s = '0;
         exp_ur = 1'b1;
      end
   endtask

   task automatic run_frame(input logic [19:0] s, input int first,
                            input int last, input int clr_at,
                            input int drop_at);
      logic [6:0] expv;
      logic [6:0] obsv;
      for (int c = first; c <= last; c++) begin
         @(negedge clock);
         underrun_clr = 1'b0;
         expv = {((c % 4) >= 2), (c >= 128), exp_bit(s, c / 4),
                 exp_ur, 3'(q.size())};
         obsv = {bclk, lrclk, sdata, underrun, level};
         vectors++;
         if (obsv !== expv) begin
            miscompares++;
            $display("FAIL frame c=%0d sample=%h bclk,lrclk,sdata,underrun,level got %b want %b",
                     c, s, obsv, expv);
         end
         if (c == clr_at) begin
            underrun_clr = 1'b1;
            exp_ur = 1'b0;
         end
         if (c == drop_at) enable = 1'b0;
      end
   endtask

   task automatic test_reset();
      logic [19:0] s;
      repeat (3) @(posedge clock);
      @(negedge clock);
      vectors++;
      if ({bclk, lrclk, sdata, underrun, level, wready} !== 8'b0000_0001) begin
         miscompares++;
         $display("FAIL reset_init: outputs got %b want 00000001",
                  {bclk, lrclk, sdata, underrun, level, wready});
      end
      reset = 1'b0;
      push_word(32'h0005A5A5);
      push_word(32'h000F0F0F);
      enable = 1'b1;
      wait_start(s);
      run_frame(s, 3, 60, -1, -1);
      reset = 1'b1;
      enable = 1'b0;
      @(negedge clock);
      reset = 1'b0;
      q.delete();
      vectors++;
      if ({bclk, lrclk, sdata, underrun, level, wready} !== 8'b0000_0001) begin
         miscompares++;
         $display("FAIL reset_mid: outputs got %b want 00000001",
                  {bclk, lrclk, sdata, underrun, level, wready});
      end
      repeat (4) begin
         @(negedge clock);
         vectors++;
         if ({bclk, lrclk, sdata, level} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_idle: bclk,lrclk,sdata,level got %b want 000000",
                     {bclk, lrclk, sdata, level});
         end
      end
   endtask

   task automatic test_single_frame();
      logic [19:0] s;
      do_reset();
      push_word(32'h000ABCDE);
      enable = 1'b1;
      wait_start(s);
      vectors++;
      if (s !== 20'hABCDE) begin
         miscompares++;
         $display("FAIL single_sb: sample got %h want abcde", s);
      end
      run_frame(s, 3, 255, -1, 40);
      repeat (8) begin
         @(negedge clock);
         vectors++;
         if ({bclk, lrclk, sdata, level} !== 6'b0) begin
            miscompares++;
            $display("FAIL single_end: bclk,lrclk,sdata,level got %b want 000000",
                     {bclk, lrclk, sdata, level});
         end
      end
   endtask

   task automatic test_fifo_full();
      logic [19:0] s;
      logic [31:0] w;
      do_reset();
      for (int k = 0; k < 5; k++) begin
         @(negedge clock);
         vectors++;
         if ({wready, level} !== {(q.size() != 4), 3'(q.size())}) begin
            miscompares++;
            $display("FAIL full_push%0d: wready,level got %b want %b", k,
                     {wready, level}, {(q.size() != 4), 3'(q.size())});
         end
         w = {12'hFFF, 20'(k * 20'h1357 + 20'h8001)};
         wvalid = 1'b1;
         wdata = w;
         if (q.size() < 4) q.push_back(w[19:0]);
      end
      @(negedge clock);
      wvalid = 1'b0;
      vectors++;
      if ({wready, level} !== 4'b0100) begin
         miscompares++;
         $display("FAIL full_level: wready,level got %b want 0100",
                  {wready, level});
      end
      enable = 1'b1;
      wait_start(s);
      run_frame(s, 3, 255, -1, -1);
      for (int f = 1; f < 4; f++) begin
         next_sample(s);
         run_frame(s, 0, 255, -1, (f == 3) ? 10 : -1);
      end
      repeat (4) begin
         @(negedge clock);
         vectors++;
         if ({bclk, underrun, level} !== 5'b0) begin
            miscompares++;
            $display("FAIL full_drain: bclk,underrun,level got %b want 00000",
                     {bclk, underrun, level});
         end
      end
   endtask

   task automatic test_underrun();
      logic [19:0] s;
      do_reset();
      push_word(32'h00012345);
      enable = 1'b1;
      wait_start(s);
      run_frame(s, 3, 255, -1, -1);
      next_sample(s);
      run_frame(s, 0, 255, 100, -1);
      next_sample(s);
      run_frame(s, 0, 255, 255, -1);
      next_sample(s);
      run_frame(s, 0, 255, -1, 10);
      repeat (4) begin
         @(negedge clock);
         vectors++;
         if ({bclk, sdata, underrun} !== 3'b001) begin
            miscompares++;
            $display("FAIL underrun_hold: bclk,sdata,underrun got %b want 001",
                     {bclk, sdata, underrun});
         end
      end
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      exp_ur = 1'b0;
      vectors++;
      if ({underrun, level, wready} !== 5'b00001) begin
         miscompares++;
         $display("FAIL underrun_reset: underrun,level,wready got %b want 00001",
                  {underrun, level, wready});
      end
   endtask

   task automatic test_enable_drop();
      logic [19:0] s;
      do_reset();
      push_word(32'h000C3C3C);
      push_word(32'h00033333);
      push_word(32'h000FEDCB);
      enable = 1'b1;
      wait_start(s);
      run_frame(s, 3, 255, -1, 40);
      repeat (16) begin
         @(negedge clock);
         vectors++;
         if ({bclk, lrclk, sdata, level} !== 6'b000_010) begin
            miscompares++;
            $display("FAIL drop_idle: bclk,lrclk,sdata,level got %b want 000010",
                     {bclk, lrclk, sdata, level});
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [19:0] s;
      do_reset();
      push_word(32'h00011111);
      push_word(32'h000A0A0A);
      push_word(32'h00077777);
      enable = 1'b1;
      wait_start(s);
      run_frame(s, 3, 255, -1, -1);
      wvalid = 1'b1;
      wdata = 32'h000DDDDD;
      q.push_back(20'hDDDDD);
      @(posedge clock);
      #1 wvalid = 1'b0;
      next_sample(s);
      run_frame(s, 0, 255, -1, 40);
      @(negedge clock);
      vectors++;
      if ({bclk, level} !== 4'b0010) begin
         miscompares++;
         $display("FAIL b2b_level: bclk,level got %b want 0010",
                  {bclk, level});
      end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_fifo_full();
      test_underrun();
      test_enable_drop();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end
endmodule
